// File: rtl/masked_hpc3_mul_bank.sv
// Bank of HPC3 masked multipliers sharing one common operand A.
// Channel k computes the shared product out_c[k] = in_b[k] * in_a over GF(2),
// bitwise per lane. It uses only its own slices of in_r/in_p.
// Every term that mixes shares is registered first. All recombination happens
// after those registers.
//
// Handshake: in_valid qualifies in_a/in_b/in_r/in_p in any cycle where
// in_enable=1. There is no ready; the bank accepts one input per enabled cycle.
// out_valid qualifies out_c. Both hold while in_enable=0. out_c is don't-care
// whenever out_valid=0.
module masked_hpc3_mul_bank #(
  parameter int NUM_SHARES   = 3,
  parameter int BIT_WIDTH    = 1,
  parameter int NUM_CHANNELS = 2,
  parameter int OUT_REG      = 0
) (
  input  logic                                            in_clock,
  input  logic                                            in_reset,
  input  logic                                            in_enable,
  input  logic                                            in_valid,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]                 in_a,
  input  logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]    in_b,
  input  logic [NUM_CHANNELS*(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0] in_r,
  input  logic [NUM_CHANNELS*(NUM_SHARES*(NUM_SHARES-1)/2)*BIT_WIDTH-1:0] in_p,
  output logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]    out_c,
  output logic                                            out_valid
);

  localparam int N  = NUM_SHARES;
  localparam int W  = BIT_WIDTH;
  localparam int CH = NUM_CHANNELS;
  localparam int NQ = N * (N - 1) / 2;

  typedef logic [W-1:0] word_t;

  // Index of share pair (i,j) with i<j. Pairs are enumerated row by row,
  // so (0,1) maps to 0.
  function automatic int pair_idx(input int i, input int j);
    return i * N - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  word_t s_d [CH][N];
  word_t s_q [CH][N];
  word_t u_d [CH][N][N];
  word_t u_q [CH][N][N];
  word_t v_d [CH][N][N];
  word_t v_q [CH][N][N];
  logic  vld_s1;
  logic [CH*N*W-1:0] c_flat;

  // Share-domain partial products. Diagonal u/v entries are tied to zero so
  // that the compression loop can run over all j without a special case.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < N; i++) begin
        s_d[k][i] = in_a[i*W +: W] & in_b[(k*N+i)*W +: W];
        for (int j = 0; j < N; j++) begin
          u_d[k][i][j] = '0;
          v_d[k][i][j] = '0;
          if (j != i) begin
            int    q;
            word_t rr;
            word_t pp;
            q  = (i < j) ? pair_idx(i, j) : pair_idx(j, i);
            rr = in_r[(k*NQ+q)*W +: W];
            pp = in_p[(k*NQ+q)*W +: W];
            u_d[k][i][j] = (in_a[i*W +: W] & (in_b[(k*N+j)*W +: W] ^ rr)) ^ pp;
            v_d[k][i][j] = (~in_a[i*W +: W] & rr) ^ pp;
          end
        end
      end
    end
  end

  // First stage: partial products and valid bit. Reset wins over enable.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      vld_s1 <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        for (int i = 0; i < N; i++) begin
          s_q[k][i] <= '0;
          for (int j = 0; j < N; j++) begin
            u_q[k][i][j] <= '0;
            v_q[k][i][j] <= '0;
          end
        end
      end
    end else if (in_enable) begin
      vld_s1 <= in_valid;
      s_q    <= s_d;
      u_q    <= u_d;
      v_q    <= v_d;
    end
  end

  // Compression: c_i = s_i ^ XOR_j (u_ij ^ v_ij). Only registered terms feed it.
  always_comb begin
    c_flat = '0;
    for (int k = 0; k < CH; k++) begin
      for (int i = 0; i < N; i++) begin
        word_t acc;
        acc = s_q[k][i];
        for (int j = 0; j < N; j++) begin
          acc = acc ^ (u_q[k][i][j] ^ v_q[k][i][j]);
        end
        c_flat[(k*N+i)*W +: W] = acc;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [CH*N*W-1:0] c_q;
    logic              vld_s2;

    // Optional second stage: registers the recombined shares and the valid bit.
    always_ff @(posedge in_clock) begin
      if (in_reset) begin
        c_q    <= '0;
        vld_s2 <= 1'b0;
      end else if (in_enable) begin
        c_q    <= c_flat;
        vld_s2 <= vld_s1;
      end
    end

    assign out_c     = c_q;
    assign out_valid = vld_s2;
  end else begin : g_no_out_reg
    assign out_c     = c_flat;
    assign out_valid = vld_s1;
  end

endmodule

// File: tb/tb_masked_hpc3_mul_bank.sv
// Testbench for masked_hpc3_mul_bank. It uses two instances:
//   dut0: 3 shares, 1 bit, 2 channels, latency 1
//   dut1: 3 shares, 8 bits, 3 channels, latency 2
// Drivers push unmasked expected products into per-instance queues.
// A monitor per instance pops a queue entry and compares it whenever the
// instance presents out_valid after an enabled edge.
module tb_masked_hpc3_mul_bank;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- dut0 signals ----------------
  logic       rst0, en0, vld0;
  logic [2:0] a0;
  logic [5:0] b0, r0, p0, c0;
  logic       ov0;

  // ---------------- dut1 signals ----------------
  logic        rst1, en1, vld1;
  logic [23:0] a1;
  logic [71:0] b1, r1, p1, c1;
  logic        ov1;

  masked_hpc3_mul_bank #(
    .NUM_SHARES(3), .BIT_WIDTH(1), .NUM_CHANNELS(2), .OUT_REG(0)
  ) dut0 (
    .in_clock (clk),
    .in_reset (rst0),
    .in_enable(en0),
    .in_valid (vld0),
    .in_a     (a0),
    .in_b     (b0),
    .in_r     (r0),
    .in_p     (p0),
    .out_c    (c0),
    .out_valid(ov0)
  );

  masked_hpc3_mul_bank #(
    .NUM_SHARES(3), .BIT_WIDTH(8), .NUM_CHANNELS(3), .OUT_REG(1)
  ) dut1 (
    .in_clock (clk),
    .in_reset (rst1),
    .in_enable(en1),
    .in_valid (vld1),
    .in_a     (a1),
    .in_b     (b1),
    .in_r     (r1),
    .in_p     (p1),
    .out_c    (c1),
    .out_valid(ov1)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [1:0]  exp0_q[$];
  logic [23:0] exp1_q[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Random 3-share sharing of one bit; share 0 sits at the LSB.
  function automatic logic [2:0] share1(input logic x);
    logic s0, s1;
    s0 = 1'($urandom);
    s1 = 1'($urandom);
    return {x ^ s0 ^ s1, s1, s0};
  endfunction

  // Random 3-share sharing of a byte.
  function automatic logic [23:0] share8(input logic [7:0] x);
    logic [7:0] s0, s1;
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    return {x ^ s0 ^ s1, s1, s0};
  endfunction

  function automatic logic [7:0] unmask8(input logic [23:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  // ---------------- driver tasks ----------------
  // ch1_rand_only=1 forces channel 0 randomness to zero.
  task automatic set0(input logic a, input logic [1:0] b, input logic valid, input bit ch1_rand_only);
    a0 = share1(a);
    b0 = {share1(b[1]), share1(b[0])};
    r0 = 6'($urandom);
    p0 = 6'($urandom);
    if (ch1_rand_only) begin
      r0[2:0] = 3'b000;
      p0[2:0] = 3'b000;
    end
    vld0 = valid;
  endtask

  task automatic issue0(input logic a, input logic [1:0] b, input logic valid, input bit ch1_rand_only);
    set0(a, b, valid, ch1_rand_only);
    en0 = 1'b1;
    if (valid) exp0_q.push_back({a & b[1], a & b[0]});
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic [7:0] a, input logic [23:0] b, input logic valid);
    a1 = share8(a);
    b1 = {share8(b[23:16]), share8(b[15:8]), share8(b[7:0])};
    r1 = {$urandom(), $urandom(), 8'($urandom())};
    p1 = {$urandom(), $urandom(), 8'($urandom())};
    vld1 = valid;
  endtask

  task automatic issue1(input logic [7:0] a, input logic [23:0] b, input logic valid);
    set1(a, b, valid);
    en1 = 1'b1;
    if (valid) exp1_q.push_back({a & b[23:16], a & b[15:8], a & b[7:0]});
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  initial begin : mon0
    logic       en_s;
    logic [1:0] got, want;
    forever begin
      @(posedge clk);
      en_s = en0;
      @(negedge clk);
      if (en_s === 1'b1 && ov0 === 1'b1) begin
        got = {^c0[5:3], ^c0[2:0]};
        if (exp0_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid0: out_valid=1 with nothing pending, out_c=%0h (t=%0t)", c0, $time);
        end else begin
          want = exp0_q.pop_front();
          check("product0", got, want);
        end
      end
    end
  end

  initial begin : mon1
    logic        en_s;
    logic [23:0] got, want;
    forever begin
      @(posedge clk);
      en_s = en1;
      @(negedge clk);
      if (en_s === 1'b1 && ov1 === 1'b1) begin
        got = {unmask8(c1[71:48]), unmask8(c1[47:24]), unmask8(c1[23:0])};
        if (exp1_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_valid1: out_valid=1 with nothing pending, out_c=%0h (t=%0t)", c1, $time);
        end else begin
          want = exp1_q.pop_front();
          check("product1", got, want);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [5:0] held0;

    // Reset with valid input presented: reset wins and the input is dropped.
    rst0 = 1'b1; en0 = 1'b1; set0(1'b1, 2'b11, 1'b1, 1'b0);
    rst1 = 1'b1; en1 = 1'b1; set1(8'hff, 24'hffffff, 1'b1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_valid0", ov0, 0);
      check("rst_out0", c0, 0);
      check("rst_valid1", ov1, 0);
      check("rst_out1", c1, 0);
    end
    rst0 = 1'b0; vld0 = 1'b0;
    rst1 = 1'b0; vld1 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("post_rst_valid0", ov0, 0);
      check("post_rst_valid1", ov1, 0);
    end
    @(posedge clk);
    #1;

    // All 8 (A,B0,B1) combinations, back to back, with random sharings and randomness.
    for (int m = 0; m < 8; m++) issue0(m[2], m[1:0], 1'b1, 1'b0);
    issue0(1'b0, 2'b00, 1'b0, 1'b0);
    issue0(1'b0, 2'b00, 1'b0, 1'b0);

    // Stall: a valid input is held while disabled. Outputs must not move.
    held0 = c0;
    set0(1'b1, 2'b10, 1'b1, 1'b0);
    en0 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid0", ov0, 0);
      check("stall_hold0", c0, held0);
    end
    en0 = 1'b1;
    exp0_q.push_back(2'b10);
    @(posedge clk);
    #1;
    issue0(1'b0, 2'b00, 1'b0, 1'b0);

    // Channel 0 randomness at zero, channel 1 random. Channel 0 shares must
    // equal a_i & B0 regardless of channel 1 randomness.
    for (int m = 0; m < 4; m++) begin
      issue0(m[1], {1'($urandom), m[0]}, 1'b1, 1'b1);
      @(negedge clk);
      check("ch0_shares", c0[2:0], a0 & {3{m[0]}});
    end
    issue0(1'b0, 2'b00, 1'b0, 1'b0);
    issue0(1'b0, 2'b00, 1'b0, 1'b0);

    // Latency-2 instance: 16 back-to-back inputs. out_valid must form one
    // gapless run two cycles behind the inputs.
    for (int i = 0; i < 18; i++) begin
      if (i < 16) issue1(8'($urandom), 24'($urandom), 1'b1);
      else        issue1(8'h00, 24'h000000, 1'b0);
      @(negedge clk);
      check("stream_valid1", ov1, (i >= 1 && i <= 16));
    end
    issue1(8'h00, 24'h000000, 1'b0);

    // Stall between the two stages: only enabled cycles count toward latency.
    issue1(8'($urandom), 24'($urandom), 1'b1);
    en1 = 1'b0;
    vld1 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid1", ov1, 0);
    end
    en1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_resume1", ov1, 1);
    issue1(8'h00, 24'h000000, 1'b0);
    issue1(8'h00, 24'h000000, 1'b0);

    // Reset mid-flight: the in-flight product is dropped and out_c is cleared.
    set1(8'hff, 24'hffffff, 1'b1);
    en1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    vld1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid1", ov1, 0);
    check("midrst_out1", c1, 0);
    rst1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_after1", ov1, 0);

    // Drain, then confirm that every expected product was seen.
    repeat (3) @(negedge clk);
    #1;
    check("pending0", exp0_q.size(), 0);
    check("pending1", exp1_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
